// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control with multi-cycle data-memory wait FSM (optional HAZ_PERF_EN perf counters)
module pipeline_hazard_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              MemtoRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemBusy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushCount
`endif
);
  localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic start, busy, ldr, pc_pend;
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] ra);
    return (RegWriteM && ra == WA3M && ra != REG_AW'(15)) ? 2'b10 :
           (RegWriteW && ra == WA3W && ra != REG_AW'(15)) ? 2'b01 : 2'b00;
  endfunction
  assign start   = MemReqM && (MEM_LATENCY > 0);
  assign busy    = (state == S_IDLE) ? start : (cnt != '0);
  assign ldr     = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
  assign pc_pend = PCSrcD || PCSrcE || PCSrcM;
  // memory wait FSM: the instruction in M is held until the access has consumed its latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state <= S_WAIT;
        cnt   <= CNT_INIT;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      state <= S_IDLE;
    end
  end
  // a memory wait freezes every stage and suppresses D/E flushes so no held instruction is lost
  always_comb begin
    ForwardAE = rst ? 2'b00 : fwd(RA1E);
    ForwardBE = rst ? 2'b00 : fwd(RA2E);
    StallF    = !rst && (busy || ldr || pc_pend);
    StallD    = !rst && (busy || ldr);
    StallE    = !rst && busy;
    StallM    = !rst && busy;
    FlushD    = !rst && !busy && (pc_pend || PCSrcW || BranchTakenE);
    FlushE    = !rst && !busy && (ldr || BranchTakenE);
    FlushW    = !rst && busy;
    MemBusy   = !rst && busy;
  end
`ifdef HAZ_PERF_EN
  // saturating counters of stalled fetch cycles and D/E flush cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && StallCycles != '1) StallCycles <= StallCycles + 1'b1;
      if ((FlushD || FlushE) && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic MemtoRegE, RegWriteM, RegWriteW, MemReqM, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy;
  logic [7:0] ctl;
  int checks = 0, errors = 0;
`ifdef HAZ_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif
  pipeline_hazard_ctrl #(.MEM_LATENCY(2), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReqM(MemReqM), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemBusy(MemBusy)
`ifdef HAZ_PERF_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );
  always #5 clk = ~clk;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {MemtoRegE, RegWriteM, RegWriteW, MemReqM, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
  endtask
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask
  initial begin
    clr();
    nxt();
    RegWriteM = 1; WA3M = 3; RA1E = 3; MemReqM = 1; PCSrcD = 1; MemtoRegE = 1; BranchTakenE = 1;
    #1;
    chk("rst_fwd", ForwardAE, 2'b00);
    chk("rst_ctl", ctl, 8'h00);
    nxt();
    rst = 0; clr();
    #1;
    chk("idle_ctl", ctl, 8'h00);
    RegWriteM = 1; WA3M = 3; RA1E = 3; RegWriteW = 1; WA3W = 3;
    #1;
    chk("fwd_m_prio", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    RA1E = 15; WA3M = 15; WA3W = 15;
    #1;
    chk("fwd_r15", ForwardAE, 2'b00);
    RegWriteM = 0; WA3M = 7; WA3W = 7; RA1E = 7; RA2E = 7;
    #1;
    chk("fwd_w_a", ForwardAE, 2'b01);
    chk("fwd_w_b", ForwardBE, 2'b01);
    RegWriteM = 1;
    #1;
    chk("fwd_m_b", ForwardBE, 2'b10);
    nxt();
    clr(); MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 2;
    #1;
    chk("ldr_use", ctl, 8'hC4);
    nxt();
    MemtoRegE = 0;
    #1;
    chk("ldr_clear", ctl, 8'h00);
    MemtoRegE = 1; RA2D = 0; RA1D = 5;
    #1;
    chk("ldr_ra1", ctl, 8'hC4);
    clr(); PCSrcE = 1;
    #1;
    chk("pc_pend", ctl, 8'h88);
    PCSrcE = 0; PCSrcW = 1;
    #1;
    chk("pc_w", ctl, 8'h08);
    PCSrcW = 0; BranchTakenE = 1;
    #1;
    chk("br_taken", ctl, 8'h0C);
    nxt();
    MemReqM = 1;
    #1;
    chk("mem_c1", ctl, 8'hF3);
    nxt();
    chk("mem_c2", ctl, 8'hF3);
    nxt();
    chk("mem_c3_br", ctl, 8'h0C);
    nxt();
    BranchTakenE = 0;
    #1;
    chk("mem_b2b_c1", ctl, 8'hF3);
    nxt();
    chk("mem_b2b_c2", ctl, 8'hF3);
    nxt();
    chk("mem_b2b_c3", ctl, 8'h00);
    nxt();
    MemReqM = 0;
    #1;
    chk("mem_idle", ctl, 8'h00);
    nxt();
    MemReqM = 1;
    #1;
    chk("rstw_c1", ctl, 8'hF3);
    nxt();
    rst = 1; RegWriteM = 1; WA3M = 4; RA2E = 4;
    #1;
    chk("rstw_ctl", ctl, 8'h00);
    chk("rstw_fwd", ForwardBE, 2'b00);
    nxt();
    rst = 0; clr();
    #1;
    chk("rstw_after", ctl, 8'h00);
    MemReqM = 1;
    #1;
    chk("rstw_idle", ctl, 8'hF3);
    nxt();
    chk("rstw_c2", ctl, 8'hF3);
    nxt();
    chk("rstw_c3", ctl, 8'h00);
`ifdef HAZ_PERF_EN
    nxt();
    rst = 1; clr();
    nxt();
    rst = 0;
    #1;
    chk("perf_rst_s", StallCycles, 32'd0);
    chk("perf_rst_f", FlushCount, 32'd0);
    MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 2;
    nxt(); nxt(); nxt();
    clr(); MemReqM = 1;
    nxt(); nxt();
    chk("perf_mem_end", ctl, 8'h00);
    MemReqM = 0;
    nxt();
    chk("perf_stalls", StallCycles, 32'd5);
    chk("perf_flush", FlushCount, 32'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard/sequencing controller for the 5-stage RSA pipeline CPU.
- Drives stall and flush controls for the F/D, D/E, E/M and M/W segment registers, and the E-stage operand forwarding selects.
- Adds a multi-cycle data-memory wait FSM that freezes the pipeline while an access in M completes.
- Sits beside the segment registers; consumes their register-address and control fields.

Parameters:
- MEM_LATENCY, 2, extra cycles a memory access in M needs (0 = single-cycle memory, FSM never leaves IDLE).
- REG_AW, 4, register-address width.

Ports:
- clk  in  1  pipeline clock; FSM and counters update on rising edge.
- rst  in  1  synchronous, active-high reset.
- RA1D, RA2D  in  REG_AW  source regs of instruction in D.
- RA1E, RA2E  in  REG_AW  source regs of instruction in E.
- WA3E, WA3M, WA3W  in  REG_AW  dest reg in E/M/W.
- MemtoRegE  in  1  E-stage instruction is a load.
- RegWriteM, RegWriteW  in  1  M/W instruction writes the register file.
- MemReqM  in  1  M-stage instruction accesses data memory (MemWriteM | MemtoRegM).
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction in that stage writes PC.
- BranchTakenE  in  1  branch resolved taken in E.
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 result W, 10 ALUOut M.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding stage/segment register.
- FlushD, FlushE, FlushW  out  1  clear the D/E/W segment register (bubble).
- MemBusy  out  1  memory wait in progress.

Behaviour:
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RA1E==WA3M & RA1E!=15; else 01 if RegWriteW & RA1E==WA3W & RA1E!=15; else 00. M has priority over W. ForwardBE is identical using RA2E.
- Load-use: ldrStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- PC write: pcPend = PCSrcD | PCSrcE | PCSrcM.
- Memory FSM, states IDLE and WAIT, counter cnt of width clog2(MEM_LATENCY+1):
  - IDLE: if MemReqM & MEM_LATENCY>0, memBusy=1, next state WAIT, cnt<=MEM_LATENCY-1; otherwise memBusy=0 and state stays IDLE.
  - WAIT, cnt!=0: memBusy=1, cnt<=cnt-1.
  - WAIT, cnt==0: memBusy=0, next state IDLE. The instruction leaves M at the end of this cycle.
  - Total stall per access is exactly MEM_LATENCY cycles. Back-to-back accesses each pay the full latency; the next access starts from IDLE on the following cycle.
- Output equations when memBusy=0:
  - StallF = ldrStall | pcPend.
  - StallD = ldrStall.
  - StallE = StallM = 0.
  - FlushD = pcPend | PCSrcW | BranchTakenE.
  - FlushE = ldrStall | BranchTakenE.
  - FlushW = 0.
- Output equations when memBusy=1 (overrides everything above):
  - StallF = StallD = StallE = StallM = 1.
  - FlushW = 1.
  - FlushD = FlushE = 0, so no frozen instruction is lost. Branch and load-use actions take effect on the first non-busy cycle, since E and D inputs are held.
- MemBusy output = memBusy.
- MemReqM must stay stable during WAIT (M is stalled). It is not re-sampled until the FSM returns to IDLE.
- Reset: while rst=1, every output is 0 (ForwardAE/BE=00, all Stall*/Flush*=0, MemBusy=0). On the clock edge, state<=IDLE and cnt<=0.
- Reset asserted mid-WAIT abandons the access; the first cycle after reset is IDLE.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: adds outputs StallCycles[31:0] (+1 each cycle StallF=1) and FlushCount[31:0] (+1 each cycle FlushD|FlushE=1). Both saturate at 32'hFFFFFFFF and clear to 0 on rst.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10. With RA1E=15 instead -> ForwardAE=00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1 for one cycle. Next cycle, with MemtoRegE=0 -> all three 0.
- MEM_LATENCY=2, MemReqM pulses -> MemBusy=1, all Stall*=1 and FlushW=1 for exactly 2 cycles; FSM back in IDLE on the 3rd cycle.
- BranchTakenE=1 during memBusy -> FlushD=FlushE=0 while busy; FlushD=FlushE=1 on the first non-busy cycle.
- rst=1 asserted during WAIT (cnt=1) -> outputs 0 while rst=1; after release with MemReqM=0, MemBusy=0.
- HAZ_PERF_EN defined, 3 load-use stalls + 2-cycle mem wait -> StallCycles=5.
